// File: rtl/nttn_host_seq_if.sv
// Bundle of command, source/result RAM and NTTN stream signals for the host sequencer.
// The master modport is the sequencer's view; the slave modport is the surrounding datapath's view.
interface nttn_host_seq_if #(
  parameter int unsigned DataSize = 64,
  parameter int unsigned AddrW    = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [AddrW-1:0]    cmd_base;
  logic [AddrW-1:0]    cmd_dst;
  logic                src_rd;
  logic [AddrW-1:0]    src_addr;
  logic [DataSize-1:0] src_rdata;
  logic                res_we;
  logic [AddrW-1:0]    res_addr;
  logic [DataSize-1:0] res_wdata;
  logic                load_w;
  logic                load_data;
  logic                start;
  logic                start_intt;
  logic [DataSize-1:0] din;
  logic                done;
  logic [DataSize-1:0] dout;
  logic                busy;
  logic                op_done;
  logic                op_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_dst, src_rdata, done, dout,
    output cmd_ready, src_rd, src_addr, res_we, res_addr, res_wdata,
           load_w, load_data, start, start_intt, din, busy, op_done, op_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_dst, src_rdata, done, dout,
    input  cmd_ready, src_rd, src_addr, res_we, res_addr, res_wdata,
           load_w, load_data, start, start_intt, din, busy, op_done, op_err
  );
endinterface

// File: rtl/nttn_host_seq.sv
// Initiator-side sequencer for the NTTN core: turns one command into the pulse/stream protocol,
// feeding din from a 1-cycle-latency source RAM and capturing the dout burst into a result RAM.
module nttn_host_seq #(
  parameter int unsigned DataSize  = 64,
  parameter int unsigned RingDepth = 10,
  parameter int unsigned PeDepth   = 3,
  parameter int unsigned AddrW     = 16,
  parameter int unsigned Gap       = 5,
  parameter int unsigned Timeout   = 65535
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  nttn_host_seq_if.master bus_io
);
  localparam int unsigned RingSize = 1 << RingDepth;
  localparam int unsigned Wn       = (((1 << (RingDepth - PeDepth)) - 1) + PeDepth) << PeDepth;
  localparam int unsigned Lw       = 2 * Wn + 2;

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StPulse  = 4'd1;
  localparam logic [3:0] StStream = 4'd2;
  localparam logic [3:0] StGap    = 4'd3;
  localparam logic [3:0] StGo     = 4'd4;
  localparam logic [3:0] StSettle = 4'd5;
  localparam logic [3:0] StWait   = 4'd6;
  localparam logic [3:0] StCapt   = 4'd7;
  localparam logic [3:0] StFin    = 4'd8;

  localparam logic [1:0] OpLoadW = 2'd0;
  localparam logic [1:0] OpNtt   = 2'd1;
  localparam logic [1:0] OpIntt  = 2'd2;
  localparam logic [1:0] OpRsvd  = 2'd3;

  logic [3:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [AddrW-1:0] base_q, base_d;
  logic [AddrW-1:0] dst_q, dst_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      stream_last;

  assign stream_last = (op_q == OpLoadW) ? 32'(Lw - 1) : 32'(RingSize - 1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          if (bus_io.cmd_op == OpRsvd) begin
            err_d = 1'b1;
          end else begin
            state_d = StPulse;
            op_d    = bus_io.cmd_op;
            base_d  = bus_io.cmd_base;
            dst_d   = bus_io.cmd_dst;
          end
        end
      end
      StPulse: begin
        state_d = StStream;
        cnt_d   = '0;
      end
      StStream: begin
        if (cnt_q == stream_last) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StGap: begin
        if (cnt_q == 32'(Gap - 1)) begin
          state_d = (op_q == OpLoadW) ? StFin : StGo;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StGo:     state_d = StSettle;
      // NTTN needs one quiet cycle after start before done is meaningful
      StSettle: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (bus_io.done) begin
          state_d = StCapt;
          cnt_d   = '0;
        end else if (cnt_q == 32'(Timeout - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StCapt: begin
        if (cnt_q == 32'(RingSize - 1)) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= OpLoadW;
      base_q  <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state so an asynchronous reset clears them without waiting for a clock.
  always_comb begin
    bus_io.cmd_ready  = (state_q == StIdle);
    bus_io.busy       = (state_q != StIdle);
    bus_io.op_done    = (state_q == StFin);
    bus_io.op_err     = err_q;
    bus_io.src_rd     = 1'b0;
    bus_io.src_addr   = '0;
    bus_io.din        = '0;
    bus_io.load_w     = 1'b0;
    bus_io.load_data  = 1'b0;
    bus_io.start      = 1'b0;
    bus_io.start_intt = 1'b0;
    bus_io.res_we     = 1'b0;
    bus_io.res_addr   = '0;
    bus_io.res_wdata  = '0;
    case (state_q)
      StPulse: begin
        bus_io.load_w    = (op_q == OpLoadW);
        bus_io.load_data = (op_q != OpLoadW);
        bus_io.src_rd    = 1'b1;
        bus_io.src_addr  = base_q;
      end
      StStream: begin
        bus_io.din = bus_io.src_rdata;
        // Prefetch word k+1 while word k is on din; nothing left to fetch on the last beat
        if (cnt_q != stream_last) begin
          bus_io.src_rd   = 1'b1;
          bus_io.src_addr = base_q + AddrW'(cnt_q + 32'd1);
        end
      end
      StGo: begin
        bus_io.start      = (op_q == OpNtt);
        bus_io.start_intt = (op_q == OpIntt);
      end
      StCapt: begin
        bus_io.res_we    = 1'b1;
        bus_io.res_addr  = dst_q + AddrW'(cnt_q);
        bus_io.res_wdata = bus_io.dout;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_nttn_host_seq.sv
// Bench for nttn_host_seq: a cycle-stamped scoreboard of expected output activity is filled at
// command issue and compared every cycle by an independent monitor; includes a small NTTN model.
module tb_nttn_host_seq;
  localparam int unsigned DataSize  = 64;
  localparam int unsigned RingDepth = 4;
  localparam int unsigned PeDepth   = 1;
  localparam int unsigned AddrW     = 16;
  localparam int unsigned Gap       = 5;
  localparam int unsigned Timeout   = 100;
  localparam int RingSize = 16;
  localparam int Lw       = 34;

  typedef struct packed {
    logic        lw, ld, st, sti, we, dn, er;
    logic [15:0] addr;
    logic [63:0] din;
    logic [63:0] wd;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nttn_host_seq_if #(.DataSize(DataSize), .AddrW(AddrW)) bus ();

  nttn_host_seq #(
    .DataSize (DataSize),
    .RingDepth(RingDepth),
    .PeDepth  (PeDepth),
    .AddrW    (AddrW),
    .Gap      (Gap),
    .Timeout  (Timeout)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  logic [63:0] src_mem [65536];
  logic [63:0] res_mem [65536];
  logic [63:0] ntt_in  [16];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          lat_cfg = 0;
  logic [1:0]  m_op;
  int          m_lat;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.src_rd) bus.src_rdata <= src_mem[bus.src_addr];
  always @(posedge clk) if (bus.res_we) res_mem[bus.res_addr] <= bus.res_wdata;

  function automatic logic [63:0] xform(logic [1:0] op, logic [63:0] w, int k);
    return (op == 2'd1) ? ((w ^ 64'h0000_0000_0000_00A0) + 64'(k)) : (~w + 64'(k));
  endfunction

  function automatic obs_t mk(logic lw, logic ld, logic st, logic sti, logic we, logic dn,
                              logic er, logic [15:0] addr, logic [63:0] din, logic [63:0] wd);
    obs_t o;
    o = '{lw: lw, ld: ld, st: st, sti: sti, we: we, dn: dn, er: er, addr: addr, din: din, wd: wd};
    return o;
  endfunction

  function automatic logic [255:0] raw_outs();
    return 256'({bus.src_addr, bus.res_addr, bus.res_wdata, bus.din, bus.busy, bus.op_done,
                 bus.op_err, bus.src_rd, bus.res_we, bus.load_w, bus.load_data, bus.start,
                 bus.start_intt, bus.cmd_ready});
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push(input int c, input obs_t v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // NTTN stand-in: collects a data burst, answers start with done after lat_cfg cycles
  // (held 3 cycles) followed by a RING_SIZE-word dout burst.
  initial begin : nttn_model
    bus.done = 1'b0;
    bus.dout = '0;
    forever begin
      @(negedge clk);
      if (bus.load_data) begin
        for (int k = 0; k < RingSize; k++) begin
          @(negedge clk);
          ntt_in[k] = bus.din;
        end
      end else if (bus.start || bus.start_intt) begin
        m_op  = bus.start ? 2'd1 : 2'd2;
        m_lat = lat_cfg;
        if (m_lat > 0) begin
          repeat (m_lat) @(posedge clk);
          #1 bus.done = 1'b1;
          for (int k = 0; k < RingSize; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) bus.done = 1'b0;
            bus.dout = xform(m_op, ntt_in[k], k);
          end
          @(posedge clk);
          #1 bus.dout = '0;
        end
      end
    end
  end

  initial begin : monitor
    obs_t got, want;
    exp_t e;
    forever begin
      @(negedge clk);
      got = mk(bus.load_w, bus.load_data, bus.start, bus.start_intt, bus.res_we, bus.op_done,
               bus.op_err, bus.res_we ? bus.res_addr : 16'h0, bus.din,
               bus.res_we ? bus.res_wdata : 64'h0);
      want = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e    = exp_q.pop_front();
        want = e.v;
      end
      chk($sformatf("outputs_cycle%0d", cyc), 256'(got), 256'(want));
    end
  end

  // Called at #1 after a posedge; returns at #1 after the posedge following acceptance.
  task automatic issue(input logic [1:0] op, input logic [15:0] base, input logic [15:0] dst,
                       input int lat, input bit fill, output int acc, output int cap);
    int n, l, g, t;
    logic [63:0] w;
    n   = 0;
    acc = -1;
    cap = -1;
    while (!bus.cmd_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_wait", 256'(bus.cmd_ready), 256'(1));
      return;
    end
    l = (op == 2'd0) ? Lw : RingSize;
    if (fill) for (int k = 0; k < l; k++) src_mem[16'(base + 16'(k))] = {$urandom, $urandom};
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_dst   = dst;
    lat_cfg       = lat;
    acc           = cyc;
    if (op == 2'd3) begin
      push(acc + 1, mk(0, 0, 0, 0, 0, 0, 1, 16'h0, 64'h0, 64'h0));
    end else begin
      push(acc + 1, mk(op == 2'd0, op != 2'd0, 0, 0, 0, 0, 0, 16'h0, 64'h0, 64'h0));
      for (int k = 0; k < l; k++) begin
        w = src_mem[16'(base + 16'(k))];
        push(acc + 2 + k, mk(0, 0, 0, 0, 0, 0, 0, 16'h0, w, 64'h0));
      end
      g = acc + 2 + l + Gap;
      if (op == 2'd0) begin
        push(g, mk(0, 0, 0, 0, 0, 1, 0, 16'h0, 64'h0, 64'h0));
      end else begin
        push(g, mk(0, 0, op == 2'd1, op == 2'd2, 0, 0, 0, 16'h0, 64'h0, 64'h0));
        if (lat == 0) begin
          push(g + 2 + Timeout, mk(0, 0, 0, 0, 0, 0, 1, 16'h0, 64'h0, 64'h0));
        end else begin
          t   = g + lat;
          cap = t + 1;
          for (int k = 0; k < RingSize; k++) begin
            w = xform(op, src_mem[16'(base + 16'(k))], k);
            push(t + 1 + k, mk(0, 0, 0, 0, 1, 0, 0, 16'(dst + 16'(k)), 64'h0, w));
          end
          push(t + 1 + RingSize, mk(0, 0, 0, 0, 0, 1, 0, 16'h0, 64'h0, 64'h0));
        end
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_base  = 16'($urandom);
    bus.cmd_dst   = 16'($urandom);
  endtask

  initial begin : main
    int acc, cap, n;
    logic [1:0]  op;
    logic [15:0] base, dst;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_base  = '0;
    bus.cmd_dst   = '0;
    #2;
    chk("reset_outputs", raw_outs(), 256'(1));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < Lw; i++) src_mem[16'h100 + i] = 64'(i + 1);
    issue(2'd0, 16'h0100, 16'h0000, 0, 1'b0, acc, cap);
    issue(2'd1, 16'h0200, 16'h0400, 50, 1'b1, acc, cap);
    issue(2'd2, 16'h0300, 16'h0500, 50, 1'b1, acc, cap);
    issue(2'd3, 16'h0600, 16'h0700, 0, 1'b0, acc, cap);
    chk("rsvd_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    chk("rsvd_busy", 256'(bus.busy), 256'(0));
    issue(2'd1, 16'h0220, 16'h0440, 0, 1'b1, acc, cap);

    for (int i = 0; i < 10; i++) begin
      op   = 2'($urandom_range(0, 3));
      base = (i == 1) ? 16'hFFF0 : 16'($urandom);
      dst  = (i == 2) ? 16'hFFF8 : 16'($urandom);
      if (i == 1) op = 2'd0;
      if (i == 2) op = 2'd2;
      issue(op, base, dst, $urandom_range(2, 90), 1'b1, acc, cap);
    end

    for (int k = 0; k < RingSize; k++) res_mem[16'h0800 + k] = 64'hDEAD_0000_0000_0000 | 64'(k);
    issue(2'd1, 16'h0280, 16'h0800, 10, 1'b1, acc, cap);
    n = 0;
    while (cyc != cap + 7 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_capt_k7", 256'(cyc), 256'(cap + 7));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_mid_capt_outputs", raw_outs(), 256'(1));
    chk("capt_word6_written", 256'(res_mem[16'h0806]), 256'(xform(2'd1, src_mem[16'h0286], 6)));
    chk("capt_word7_untouched", 256'(res_mem[16'h0807]), 256'(64'hDEAD_0000_0000_0007));
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2'd1, 16'h02A0, 16'h0900, 30, 1'b1, acc, cap);

    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
